s_u_seqdiv16_8: RTL and testbench

Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor, giving an N-bit quotient and an N-bit remainder. It is the inverse operator of the N×N unsigned multipliers in the arithmetic library. Its main use is inverting exact or approximate 2N-bit products, for example in error-analysis harnesses that recover an operand from a product. It computes one quotient bit per clock and uses valid/ready handshakes on both input and output.

---
 rtl/s_u_seqdiv16_8_if.sv | 26 ++
 rtl/s_u_seqdiv16_8.sv | 133 +++++++++++++
 tb/tb_s_u_seqdiv16_8.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/s_u_seqdiv16_8_if.sv
// Handshake bundle for the sequential unsigned divider: operand channel in,
// result channel out, each with its own valid/ready pair.
interface s_u_seqdiv16_8_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/s_u_seqdiv16_8.sv
// Restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per
// clock. Divide-by-zero and quotient overflow are resolved at accept time.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | N restoring iterations, one quotient bit per edge
// DONE  | result presented, waiting for out_ready
module s_u_seqdiv16_8 #(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst_n,
  s_u_seqdiv16_8_if.slave bus
);
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]     rem_q;
  logic [N-1:0]     sreg;
  logic [N-1:0]     dvsr;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic [N-1:0]     quot_q;
  logic [N-1:0]     rema_q;
  logic             dbz_q;
  logic             ovf_q;

  logic             in_ready_c;
  logic             accept;
  logic             is_zero;
  logic             is_ovf;
  logic             last_iter;
  logic [N:0]       t_val;
  logic             t_ge;
  logic [N-1:0]     rem_nxt;

  assign accept    = bus.in_valid && in_ready_c;
  assign is_zero   = (bus.divisor == '0);
  assign is_ovf    = (bus.dividend[2*N-1:N] >= bus.divisor);
  assign last_iter = (cnt == CNT_W'(N-1));

  // R never reaches the divisor, so N bits hold it; T carries the extra bit.
  always_comb begin
    t_val   = {rem_q, sreg[N-1]};
    t_ge    = (t_val >= {1'b0, dvsr});
    rem_nxt = t_ge ? (t_val[N-1:0] - dvsr) : t_val[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_zero || is_ovf) ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    if (rst_n && state == IDLE) in_ready_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= '0;
      sreg        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rema_q      <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvsr <= bus.divisor;
            if (is_zero) begin
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
              quot_q      <= '1;
              rema_q      <= bus.dividend[N-1:0];
              out_valid_q <= 1'b1;
            end else if (is_ovf) begin
              dbz_q       <= 1'b0;
              ovf_q       <= 1'b1;
              quot_q      <= '1;
              rema_q      <= '0;
              out_valid_q <= 1'b1;
            end else begin
              rem_q <= bus.dividend[2*N-1:N];
              sreg  <= bus.dividend[N-1:0];
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          rem_q <= rem_nxt;
          sreg  <= {sreg[N-2:0], t_ge};
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            quot_q      <= {sreg[N-2:0], t_ge};
            rema_q      <= rem_nxt;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rema_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_s_u_seqdiv16_8.sv
// Scoreboard bench for s_u_seqdiv16_8: directed vectors, handshake timing,
// backpressure, reset mid-operation and a round-trip / modelled random sweep.
module tb_s_u_seqdiv16_8;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  s_u_seqdiv16_8_if #(.N(8)) bus ();

  s_u_seqdiv16_8 #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                              input logic dz, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: a result is consumed on the edge after a negedge seeing valid&ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got q=%0h r=%0h, required none (t=%0t)",
                 bus.quotient, bus.remainder, $time);
      end else begin
        e = sb.pop_front();
        check("quotient",    32'(bus.quotient),    32'(e.q));
        check("remainder",   32'(bus.remainder),   32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
        check("overflow",    32'(bus.overflow),    32'(e.ov));
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic send(input logic [15:0] dd, input logic [7:0] dv, input exp_t e);
    int n = 0;
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen; in_ready must stay low.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int a, b;
    logic [15:0] dd;
    logic [7:0]  dv, hi;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;

    #13;
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),    32'd0);
    check("rst_quotient",  32'(bus.quotient),    32'd0);
    check("rst_remainder", 32'(bus.remainder),   32'd0);
    check("rst_dbz",       32'(bus.div_by_zero), 32'd0);
    check("rst_ovf",       32'(bus.overflow),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // basic divide with latency
    send(16'd1000, 8'd7, mk(8'd142, 8'd6, 1'b0, 1'b0));
    wait_valid(lat);
    check("latency_1000_7", 32'(lat), 32'd8);

    // just below overflow, then overflow
    send(16'hFEFF, 8'hFF, mk(8'hFF, 8'hFE, 1'b0, 1'b0));
    wait_valid(lat);
    check("latency_FEFF_FF", 32'(lat), 32'd8);
    send(16'hFFFF, 8'hFF, mk(8'hFF, 8'h00, 1'b0, 1'b1));
    wait_valid(lat);
    check("latency_overflow", 32'(lat), 32'd0);

    // divide by zero
    send(16'h1234, 8'h00, mk(8'hFF, 8'h34, 1'b1, 1'b0));
    wait_valid(lat);
    check("latency_dbz", 32'(lat), 32'd0);

    // small boundaries
    send(16'd0,    8'd5, mk(8'd0,   8'd0, 1'b0, 1'b0));
    send(16'h00FF, 8'd1, mk(8'hFF,  8'd0, 1'b0, 1'b0));
    send(16'h0100, 8'd1, mk(8'hFF,  8'd0, 1'b0, 1'b1));
    send(16'd255,  8'd16, mk(8'd15, 8'd15, 1'b0, 1'b0));

    // backpressure with in_valid held high on other operands
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.out_ready = 1'b0;
    send(16'd200, 8'd13, mk(8'd15, 8'd5, 1'b0, 1'b0));
    wait_valid(lat);
    check("latency_200_13", 32'(lat), 32'd8);
    bus.in_valid = 1'b1;
    bus.dividend = 16'h1111;
    bus.divisor  = 8'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_quotient",  32'(bus.quotient),  32'd15);
      check("bp_remainder", 32'(bus.remainder), 32'd5);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_xfer_valid", 32'(bus.out_valid), 32'd0);
    check("bp_after_xfer_idle",  32'(bus.in_ready),  32'd1);
    sb.push_back(mk(8'hFF, 8'h00, 1'b0, 1'b1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_next_accept_ready", 32'(bus.in_ready),  32'd0);
    check("bp_next_accept_valid", 32'(bus.out_valid), 32'd1);

    // reset after iteration 4
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    send(16'hABCD, 8'hC1, mk(8'd227, 8'd170, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    check("mid_before_reset_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),    32'd0);
    check("mid_rst_quotient",  32'(bus.quotient),    32'd0);
    check("mid_rst_remainder", 32'(bus.remainder),   32'd0);
    check("mid_rst_dbz",       32'(bus.div_by_zero), 32'd0);
    check("mid_rst_ovf",       32'(bus.overflow),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready),  32'd1);
    check("post_rst_valid",    32'(bus.out_valid), 32'd0);
    send(16'd100, 8'd3, mk(8'd33, 8'd1, 1'b0, 1'b0));
    wait_valid(lat);
    check("latency_100_3", 32'(lat), 32'd8);

    // round trip a*b / b
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom_range(0, 255);
      b  = $urandom_range(1, 255);
      dd = 16'(a * b);
      send(dd, 8'(b), mk(8'(a), 8'd0, 1'b0, 1'b0));
    end

    // random legal operands against the bench's own / and %
    for (int i = 0; i < 500; i++) begin
      dv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(dv) - 1));
      dd = {hi, 8'($urandom_range(0, 255))};
      send(dd, dv, mk(8'(dd / 16'(dv)), 8'(dd % 16'(dv)), 1'b0, 1'b0));
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
